// File: rtl/iq_fetch_ctrl.sv
// iq_fetch_ctrl: credit-based fetch scheduler; ports clk/rst, flush_i/redirect_pc_i, req_*/resp_*, push_valid_o, pop_num_i, credits_o, perf counters (IQ_FETCH_PERF_EN)
module iq_fetch_ctrl #(
  parameter int          IQ_CAP       = 16,
  parameter int          MAX_INFLIGHT = 2,
  parameter logic [31:0] RESET_PC     = 32'hBFC00000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [31:0]               redirect_pc_i,
  output logic                      req_valid_o,
  input  logic                      req_ready_i,
  output logic [31:0]               req_pc_o,
  input  logic                      resp_valid_i,
  input  logic [2:0]                resp_num_i,
  output logic                      push_valid_o,
  input  logic [1:0]                pop_num_i,
  output logic [$clog2(IQ_CAP):0]   credits_o,
  output logic [31:0]               stall_cnt_o,
  output logic [31:0]               drop_cnt_o
);
  localparam int CW = $clog2(IQ_CAP) + 1;
  localparam logic [0:0] RUN = 1'b0, DRAIN = 1'b1;
  logic [0:0] state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [CW-1:0] credits_q, credits_d;
  logic [2:0] out_q, out_d, stale_q, stale_d;
  logic hs;
  logic [CW:0] add_c, take_c, sum_c;
  always_comb begin
    req_valid_o = !rst && state_q == RUN && !flush_i && credits_q >= CW'(4) && out_q < 3'(MAX_INFLIGHT);
    hs = req_valid_o && req_ready_i;
    push_valid_o = !rst && state_q == RUN && resp_valid_i && !flush_i;
    add_c = {1'b0, credits_q} + (CW+1)'(pop_num_i) + (push_valid_o ? (CW+1)'(3'd4 - resp_num_i) : '0);
    take_c = hs ? (CW+1)'(4) : '0;
    sum_c = add_c - take_c;
    pc_d = flush_i ? redirect_pc_i : hs ? {pc_q[31:4] + 28'd1, 4'b0} : pc_q;
    credits_d = flush_i ? CW'(IQ_CAP) : sum_c[CW-1:0];
    out_d = flush_i ? 3'd0 : out_q + 3'(hs) - 3'(push_valid_o);
    // a response arriving with the flush is already accounted for, so it is not stale
    stale_d = state_q == DRAIN ? stale_q - 3'(resp_valid_i) : flush_i ? out_q - 3'(resp_valid_i) : stale_q;
    state_d = (flush_i || state_q == DRAIN) ? (stale_d != 3'd0 ? DRAIN : RUN) : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      credits_q <= CW'(IQ_CAP);
      out_q     <= '0;
      stale_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      credits_q <= credits_d;
      out_q     <= out_d;
      stale_q   <= stale_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (flush_i || add_c >= take_c) else $error("credit underflow");
      assert (flush_i || sum_c <= (CW+1)'(IQ_CAP)) else $error("credit overflow");
      assert (out_d <= 3'(MAX_INFLIGHT)) else $error("outstanding overflow");
      assert (!(state_q == RUN && resp_valid_i && out_q == 3'd0)) else $error("response without request");
    end
  end
  assign req_pc_o  = pc_q;
  assign credits_o = credits_q;
`ifdef IQ_FETCH_PERF_EN
  logic [31:0] stall_q, stall_d, drop_q, drop_d;
  always_comb begin
    stall_d = stall_q + 32'(state_q == RUN && !flush_i && credits_q < CW'(4));
    drop_d = drop_q + 32'(resp_valid_i && (flush_i || state_q == DRAIN));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      stall_q <= stall_d;
      drop_q  <= drop_d;
    end
  end
  assign stall_cnt_o = stall_q;
  assign drop_cnt_o  = drop_q;
`else
  assign stall_cnt_o = 32'd0;
  assign drop_cnt_o  = 32'd0;
`endif
endmodule
